cache_axi_read_arbiter: RTL and testbench

Shares the single AXI read channel (AR/R) of the CPU core between the instruction-cache refill port and the data-cache refill/uncached port. Allows one outstanding transaction at a time. Arbitration is round-robin. Sits between inst_cache_fifo, the dcache and the AXI interconnect. The cache-facing sides use the same valid/ready/last semantics as the AXI master side.

---
 rtl/cache_axi_read_arbiter.sv | 178 +++++++++++++++++
 tb/tb_cache_axi_read_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read channel (AR/R) between the
// icache refill port (i_*) and the dcache refill/uncached port (d_*).
// One transaction is outstanding at a time.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   i_araddr/i_arvalid/i_arready   icache request (arready is a 1-cycle pulse)
//   i_rdata/i_rvalid/i_rlast/i_rready  icache read data
//   d_araddr/d_arlen/d_arvalid/d_arready  dcache request (arready is a pulse)
//   d_rdata/d_rvalid/d_rlast/d_rready  dcache read data
//   m_ar*                          AXI AR master channel
//   m_r*                           AXI R master channel
//   err                            protocol-error pulse, one cycle after detection
module cache_axi_read_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter logic [7:0]  ILEN   = 8'd7,
  parameter logic [3:0]  IID    = 4'd0,
  parameter logic [3:0]  DID    = 4'd1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic              i_arvalid,
  output logic              i_arready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic              i_rlast,
  input  logic              i_rready,
  input  logic [ADDR_W-1:0] d_araddr,
  input  logic [7:0]        d_arlen,
  input  logic              d_arvalid,
  output logic              d_arready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_rlast,
  input  logic              d_rready,
  output logic [3:0]        m_arid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [3:0]        m_rid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              err
);

  localparam int unsigned CNT_W = 9;
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t             state, state_nxt;
  logic               grant, grant_nxt;
  logic               last_grant, last_grant_nxt;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
  logic [ADDR_W-1:0]  araddr_nxt;
  logic [7:0]         arlen_nxt;
  logic [3:0]         arid_nxt;
  logic               arvalid_nxt;
  logic               i_arready_nxt;
  logic               d_arready_nxt;
  logic               err_nxt;
  logic               pick_d;
  logic               gnt_rready;
  logic               beat_acc;
  logic               exp_last;

  assign m_arsize  = 3'b010;
  assign m_arburst = 2'b01;

  // Tie goes to whoever did not win the previous transaction.
  assign pick_d = (i_arvalid & d_arvalid) ? (last_grant == GNT_I) : d_arvalid;

  // R path: pure combinational routing to the granted side.
  always_comb begin
    gnt_rready = (grant == GNT_D) ? d_rready : i_rready;
    m_rready   = (state == DATA) & gnt_rready;
    i_rvalid   = (state == DATA) & (grant == GNT_I) & m_rvalid;
    i_rlast    = (state == DATA) & (grant == GNT_I) & m_rlast;
    d_rvalid   = (state == DATA) & (grant == GNT_D) & m_rvalid;
    d_rlast    = (state == DATA) & (grant == GNT_D) & m_rlast;
    i_rdata    = m_rdata;
    d_rdata    = m_rdata;
    beat_acc   = (state == DATA) & m_rvalid & gnt_rready;
    exp_last   = (beat_cnt == CNT_W'(m_arlen));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    araddr_nxt     = m_araddr;
    arlen_nxt      = m_arlen;
    arid_nxt       = m_arid;
    arvalid_nxt    = m_arvalid;
    i_arready_nxt  = 1'b0;
    d_arready_nxt  = 1'b0;
    err_nxt        = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_arvalid | d_arvalid) begin
          grant_nxt    = pick_d;
          arvalid_nxt  = 1'b1;
          beat_cnt_nxt = '0;
          state_nxt    = ADDR;
          if (pick_d) begin
            araddr_nxt    = d_araddr;
            arlen_nxt     = d_arlen;
            arid_nxt      = DID;
            d_arready_nxt = 1'b1;
          end else begin
            araddr_nxt    = i_araddr;
            arlen_nxt     = ILEN;
            arid_nxt      = IID;
            i_arready_nxt = 1'b1;
          end
        end
      end
      ADDR: begin
        if (m_arready) begin
          arvalid_nxt = 1'b0;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (beat_acc) begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
          // Wrong id, early/late last: flagged but the burst still completes.
          err_nxt      = (m_rid != m_arid) | (m_rlast != exp_last);
          if (m_rlast) begin
            state_nxt      = IDLE;
            last_grant_nxt = grant;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= GNT_I;
      last_grant <= GNT_I;
      beat_cnt   <= '0;
      m_arvalid  <= 1'b0;
      m_araddr   <= '0;
      m_arlen    <= '0;
      m_arid     <= '0;
      i_arready  <= 1'b0;
      d_arready  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
      m_arvalid  <= arvalid_nxt;
      m_araddr   <= araddr_nxt;
      m_arlen    <= arlen_nxt;
      m_arid     <= arid_nxt;
      i_arready  <= i_arready_nxt;
      d_arready  <= d_arready_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_cache_axi_read_arbiter.sv
// Self-checking bench for cache_axi_read_arbiter: directed scenarios followed
// by randomized traffic, checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_cache_axi_read_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] i_araddr;
  logic              i_arvalid;
  logic              i_arready;
  logic [DATA_W-1:0] i_rdata;
  logic              i_rvalid;
  logic              i_rlast;
  logic              i_rready;
  logic [ADDR_W-1:0] d_araddr;
  logic [7:0]        d_arlen;
  logic              d_arvalid;
  logic              d_arready;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rvalid;
  logic              d_rlast;
  logic              d_rready;
  logic [3:0]        m_arid;
  logic [ADDR_W-1:0] m_araddr;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [1:0]        m_arburst;
  logic              m_arvalid;
  logic              m_arready;
  logic [3:0]        m_rid;
  logic [DATA_W-1:0] m_rdata;
  logic              m_rlast;
  logic              m_rvalid;
  logic              m_rready;
  logic              err;

  always #5 clk = ~clk;

  cache_axi_read_arbiter dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arvalid(i_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_rready(d_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready), .err(err)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; } dreq_t;

  logic [31:0] iq[$];
  dreq_t       dq[$];
  bit          grants[$];
  logic [7:0]  lens [5];

  int errors = 0;
  int checks = 0;

  // Reference model: one transaction tracked by owner, AR phase and beats.
  bit          busy, own_d, ar_pend, fresh, last_d, err_exp, chk_rst;
  logic [31:0] t_addr;
  logic [7:0]  t_len;
  logic [3:0]  t_id;
  int          beats;

  // Slave responder and knobs.
  bit          s_has, s_rv, rnd_mode, bp_en;
  int          s_k, s_last, s_badid, ar_cnt, ar_stall;
  logic [31:0] s_base, dir_base;
  int          dir_stall, dir_off, rst_cycles, bp_cnt;

  // Observations.
  int cyc, irx, drx, i_last_at, err_seen, iarr_seen, av_run, av_max;
  int d_end_cyc, i_ar_cyc;
  bit prev_av;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    bit rr, beat, was_fresh, dp;
    int sel, off;
    dreq_t r;
    @(negedge clk);
    cyc++;
    if (rst) begin
      busy = 0; ar_pend = 0; fresh = 0; last_d = 0; err_exp = 0;
      s_has = 0; s_rv = 0; chk_rst = 1; prev_av = 0;
    end else begin
      if (chk_rst) begin
        chk_rst = 0;
        check_eq("rst_araddr", 64'(m_araddr), 64'(0));
        check_eq("rst_arlen", 64'(m_arlen), 64'(0));
        check_eq("rst_arid", 64'(m_arid), 64'(0));
        check_eq("arsize", 64'(m_arsize), 64'(3'b010));
        check_eq("arburst", 64'(m_arburst), 64'(2'b01));
      end
      dp = busy && !ar_pend;
      rr = own_d ? d_rready : i_rready;
      check_eq("m_arvalid", 64'(m_arvalid), 64'(busy && ar_pend));
      if (busy && ar_pend) begin
        check_eq("m_araddr", 64'(m_araddr), 64'(t_addr));
        check_eq("m_arlen", 64'(m_arlen), 64'(t_len));
        check_eq("m_arid", 64'(m_arid), 64'(t_id));
      end
      check_eq("i_arready", 64'(i_arready), 64'(fresh && !own_d));
      check_eq("d_arready", 64'(d_arready), 64'(fresh && own_d));
      check_eq("m_rready", 64'(m_rready), 64'(dp && rr));
      check_eq("i_rvalid", 64'(i_rvalid), 64'(dp && !own_d && m_rvalid));
      check_eq("i_rlast", 64'(i_rlast), 64'(dp && !own_d && m_rlast));
      check_eq("d_rvalid", 64'(d_rvalid), 64'(dp && own_d && m_rvalid));
      check_eq("d_rlast", 64'(d_rlast), 64'(dp && own_d && m_rlast));
      if (dp && m_rvalid)
        check_eq(own_d ? "d_rdata" : "i_rdata", 64'(own_d ? d_rdata : i_rdata), 64'(m_rdata));
      check_eq("err", 64'(err), 64'(err_exp));

      if (i_rvalid && i_rready) begin irx++; if (i_rlast) i_last_at = irx; end
      if (d_rvalid && d_rready) begin drx++; if (d_rlast) d_end_cyc = cyc; end
      if (m_arvalid && !prev_av && m_arid == 4'd0) i_ar_cyc = cyc;
      prev_av = m_arvalid;
      av_run = m_arvalid ? av_run + 1 : 0;
      if (av_run > av_max) av_max = av_run;
      if (err) err_seen++;
      if (i_arready) iarr_seen++;

      was_fresh = fresh; fresh = 0; err_exp = 0;
      beat = dp && m_rvalid && rr;
      if (!busy) begin
        if (i_arvalid || d_arvalid) begin
          own_d = (i_arvalid && d_arvalid) ? !last_d : d_arvalid;
          busy = 1; ar_pend = 1; fresh = 1; ar_cnt = 0;
          ar_stall = rnd_mode ? int'($urandom_range(0, 3)) : dir_stall;
          if (own_d) begin t_addr = d_araddr; t_len = d_arlen; t_id = 4'd1; end
          else       begin t_addr = i_araddr; t_len = 8'd7;    t_id = 4'd0; end
          grants.push_back(own_d);
        end
      end else if (ar_pend) begin
        if (m_arready) begin
          ar_pend = 0; beats = 0; s_has = 1; s_k = 0; s_rv = 0;
          s_base = rnd_mode ? $urandom() : dir_base;
          if (rnd_mode) begin
            sel = int'($urandom_range(0, 19));
            off = (sel == 0 && t_len > 0) ? -1 : (sel == 1) ? 1 : 0;
            s_badid = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, int'(t_len))) : -1;
          end else begin
            off = dir_off; s_badid = -1;
          end
          s_last = int'(t_len) + off;
        end
      end else if (beat) begin
        err_exp = (m_rid != t_id) || (m_rlast != (beats == int'(t_len)));
        beats++; s_k++; s_rv = 0;
        if (m_rlast) begin busy = 0; last_d = own_d; s_has = 0; end
      end
      if (was_fresh) begin
        if (own_d) void'(dq.pop_front()); else void'(iq.pop_front());
      end
    end

    @(posedge clk); #1;
    rst = (rst_cycles > 0);
    if (rst_cycles > 0) rst_cycles--;
    if (rnd_mode) begin
      if (iq.size() < 2 && $urandom_range(0, 9) == 0) iq.push_back($urandom() & 32'hFFFF_FFE0);
      if (dq.size() < 2 && $urandom_range(0, 9) == 0) begin
        r.addr = $urandom(); r.len = lens[$urandom_range(0, 4)]; dq.push_back(r);
      end
    end
    i_arvalid = (iq.size() > 0);
    i_araddr  = (iq.size() > 0) ? iq[0] : 32'h0;
    d_arvalid = (dq.size() > 0);
    d_araddr  = (dq.size() > 0) ? dq[0].addr : 32'h0;
    d_arlen   = (dq.size() > 0) ? dq[0].len : 8'h0;
    if (rnd_mode) begin
      i_rready = ($urandom_range(0, 3) != 0);
      d_rready = ($urandom_range(0, 3) != 0);
    end else begin
      d_rready = 1'b1;
      if (bp_en && ((irx == 2 && bp_cnt < 1) || (irx == 3 && bp_cnt < 2))) begin
        i_rready = 1'b0; bp_cnt++;
      end else i_rready = 1'b1;
    end
    if (busy && ar_pend) begin
      m_arready = (ar_cnt >= ar_stall); ar_cnt++;
    end else m_arready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
    if (s_has) begin
      if (!s_rv) begin
        if (!rnd_mode || $urandom_range(0, 9) < 7) begin
          s_rv = 1; m_rvalid = 1'b1;
          m_rdata = s_base + 32'(s_k);
          m_rlast = (s_k == s_last);
          m_rid   = (s_k == s_badid) ? (t_id ^ 4'h1) : t_id;
        end else m_rvalid = 1'b0;
      end
    end else begin
      s_rv = 0;
      m_rvalid = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      m_rlast  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      m_rid    = rnd_mode ? 4'($urandom()) : 4'h0;
      m_rdata  = $urandom();
    end
  endtask

  task automatic run_until_done(input string tag, input int max);
    int n;
    n = 0;
    while ((iq.size() > 0 || dq.size() > 0 || busy) && n < max) begin step(); n++; end
    repeat (2) step();
    check_eq({tag, "_done"}, 64'(iq.size() + dq.size() + int'(busy)), 64'(0));
  endtask

  task automatic clear_stats();
    irx = 0; drx = 0; i_last_at = 0; err_seen = 0; iarr_seen = 0;
    av_max = 0; d_end_cyc = -1; i_ar_cyc = -1; bp_cnt = 0;
    grants.delete();
  endtask

  task automatic do_reset();
    rst_cycles = 1;
    repeat (3) step();
  endtask

  initial begin
    int n;
    dreq_t r;
    lens = '{8'd0, 8'd1, 8'd3, 8'd7, 8'd15};
    rst = 1'b1; rst_cycles = 0; rnd_mode = 0; bp_en = 0;
    dir_stall = 0; dir_off = 0; dir_base = 32'h0; s_badid = -1;
    i_araddr = '0; i_arvalid = 0; i_rready = 1; d_araddr = '0; d_arlen = '0;
    d_arvalid = 0; d_rready = 1; m_arready = 0; m_rid = '0; m_rdata = '0;
    m_rlast = 0; m_rvalid = 0;
    busy = 0; last_d = 0; fresh = 0; ar_pend = 0; err_exp = 0; cyc = 0; av_run = 0;
    clear_stats();
    repeat (2) step();

    // Icache only, 8-beat refill.
    clear_stats(); dir_base = 32'hFEDC_BA90;
    iq.push_back(32'h0);
    run_until_done("t1", 200);
    check_eq("t1_irx", 64'(irx), 64'(8));
    check_eq("t1_rlast_at", 64'(i_last_at), 64'(8));
    check_eq("t1_drx", 64'(drx), 64'(0));
    check_eq("t1_err", 64'(err_seen), 64'(0));
    check_eq("t1_arready_pulses", 64'(iarr_seen), 64'(1));

    // Simultaneous requests after reset: dcache wins, then 1 idle cycle.
    do_reset();
    clear_stats(); dir_base = 32'h1234_0000;
    iq.push_back(32'h20);
    r.addr = 32'h8000_1000; r.len = 8'd0; dq.push_back(r);
    run_until_done("t2", 200);
    check_eq("t2_ngrants", 64'(grants.size()), 64'(2));
    if (grants.size() == 2) begin
      check_eq("t2_first", 64'(grants[0]), 64'(1));
      check_eq("t2_second", 64'(grants[1]), 64'(0));
    end
    check_eq("t2_drx", 64'(drx), 64'(1));
    check_eq("t2_irx", 64'(irx), 64'(8));
    check_eq("t2_gap", 64'(i_ar_cyc - d_end_cyc), 64'(2));

    // Fairness with both requesters continuously valid.
    clear_stats();
    repeat (2) begin
      iq.push_back(32'h100);
      r.addr = 32'h9000_0000; r.len = 8'd3; dq.push_back(r);
    end
    run_until_done("t3", 400);
    check_eq("t3_ngrants", 64'(grants.size()), 64'(4));
    for (int k = 0; k < 4 && k < grants.size(); k++)
      check_eq($sformatf("t3_grant%0d", k), 64'(grants[k]), 64'(k % 2 == 0));

    // AR stall: arready low for 3 cycles.
    clear_stats(); dir_stall = 3;
    iq.push_back(32'h40);
    run_until_done("t4", 200);
    check_eq("t4_arvalid_cycles", 64'(av_max), 64'(4));
    dir_stall = 0;

    // Backpressure on icache beats 3 and 4.
    clear_stats(); bp_en = 1;
    iq.push_back(32'h60);
    run_until_done("t5a", 200);
    check_eq("t5a_irx", 64'(irx), 64'(8));
    check_eq("t5a_bp_cycles", 64'(bp_cnt), 64'(2));
    check_eq("t5a_err", 64'(err_seen), 64'(0));
    bp_en = 0;

    // Early rlast on beat 5 of 8.
    clear_stats(); dir_off = -3;
    iq.push_back(32'h80);
    run_until_done("t5b", 200);
    check_eq("t5b_irx", 64'(irx), 64'(5));
    check_eq("t5b_err", 64'(err_seen), 64'(1));
    dir_off = 0;

    // Reset mid-burst, then a normal refill.
    clear_stats();
    iq.push_back(32'hA0);
    n = 0;
    while (irx < 4 && n < 200) begin step(); n++; end
    check_eq("t6_reach4", 64'(irx), 64'(4));
    do_reset();
    clear_stats();
    iq.push_back(32'hC0);
    run_until_done("t6", 200);
    check_eq("t6_irx", 64'(irx), 64'(8));
    check_eq("t6_err", 64'(err_seen), 64'(0));

    // Randomized traffic with occasional protocol errors.
    clear_stats(); rnd_mode = 1;
    repeat (3000) step();
    rnd_mode = 0;
    run_until_done("rnd", 2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
